// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle MIPS-subset datapath; define MC_DATAPATH_BNE_EN to enable bne (opcode 0x05)
module mc_datapath #(
  parameter int DATA_W = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [DATA_W-1:0] pc,
  output logic              retire,
  output logic              halted
);
  localparam int RW = $clog2(NREG);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state;
  logic [31:0] ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr, imm, alu, wb_val;
  logic [DATA_W-1:0] rf [NREG];
  logic [5:0] op, fn;
  logic [RW-1:0] rs, rt, rd, wb_idx;
  logic r_ok, is_bne, is_br, is_j, is_mem, is_halt, supported, br_take;
  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign rs = ir[21 +: RW];
  assign rt = ir[16 +: RW];
  assign rd = ir[11 +: RW];
  assign imm = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign r_ok = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
`ifdef MC_DATAPATH_BNE_EN
  assign is_bne = op == 6'h05;
`else
  assign is_bne = 1'b0;
`endif
  assign is_br = op == 6'h04 || is_bne;
  assign is_j = op == 6'h02;
  assign is_mem = op == 6'h23 || op == 6'h2B;
  assign is_halt = op == 6'h3F;
  assign supported = r_ok || op == 6'h08 || is_mem || is_br || is_j;
  assign br_take = is_bne ? a != b : a == b;
  always_comb begin
    alu = a + b;
    if (op != 6'h00) alu = a + imm;
    else if (fn == 6'h22) alu = a - b;
    else if (fn == 6'h24) alu = a & b;
    else if (fn == 6'h25) alu = a | b;
    else if (fn == 6'h2A) alu = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
  end
  assign wb_idx = op == 6'h00 ? rd : rt;
  assign wb_val = op == 6'h23 ? mdr : alu_out;
  assign imem_addr = pc;
  assign dmem_req = state == MEM;
  assign dmem_we = state == MEM && op == 6'h2B;
  assign dmem_addr = alu_out;
  assign dmem_wdata = b;
  assign halted = state == HALT;
  // last cycle of each instruction class; halt retires in its DECODE cycle like a NOP
  assign retire = state == WB || (state == DECODE && !supported) || (state == EXEC && (is_br || is_j))
                  || (state == MEM && op == 6'h2B && dmem_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= '0;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir <= imem_rdata;
          pc <= pc + DATA_W'(4);
          state <= DECODE;
        end
        DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
          state <= is_halt ? HALT : supported ? EXEC : FETCH;
        end
        EXEC: begin
          alu_out <= alu;
          if (is_br && br_take) pc <= pc + {imm[DATA_W-3:0], 2'b00};
          if (is_j) pc <= {pc[DATA_W-1:28], ir[25:0], 2'b00};
          state <= (is_br || is_j) ? FETCH : is_mem ? MEM : WB;
        end
        MEM: if (dmem_ready) begin
          mdr <= dmem_rdata;
          state <= op == 6'h23 ? WB : FETCH;
        end
        WB: begin
          if (wb_idx != '0) rf[wb_idx] <= wb_val;
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed programs plus random forward-only programs checked against an ISA-level model
module tb_mc_datapath;
  localparam int W = 32;
  localparam int NR = 32;
  logic clk = 0, rst = 1;
  logic [W-1:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [31:0] imem_rdata;
  logic dmem_req, dmem_we, dmem_ready = 0, retire, halted;
  logic [31:0] imem [256];
  logic [W-1:0] dmem [64];
  logic [W-1:0] mreg [NR];
  logic [W-1:0] mmem [64];
  logic [W-1:0] mpc, e_addr, e_wd;
  int e_cyc, checks = 0, errors = 0, mcnt = 0, dly = 0, fixed_dly = 0, last_cyc;
  bit e_mem, e_we, e_halt;
  mc_datapath #(.DATA_W(W), .NREG(NR)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .pc(pc), .retire(retire), .halted(halted));
  always #5 clk = ~clk;
  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_rdata = dmem[dmem_addr[7:2]];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 64; i++) dmem[i] <= '0;
    else if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr[7:2]] <= dmem_wdata;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] r_i(int f, int s, int t, int d);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, 6'(f)};
  endfunction
  function automatic logic [31:0] i_i(int o, int s, int t, int im);
    return {6'(o), 5'(s), 5'(t), 16'(im)};
  endfunction
  function automatic logic [31:0] j_i(int tgt);
    return {6'h02, 26'(tgt)};
  endfunction
  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'hFC00_0000;
  endtask
  // ISA-level reference: executes the instruction at mpc and records what the bus/timing should show
  task automatic mstep();
    logic [31:0] in;
    logic [W-1:0] av, bv, im, r;
    int s, t, d, sv, wi;
    bit wr;
    in = imem[mpc[9:2]];
    s = int'(in[25:21]) % NR;
    t = int'(in[20:16]) % NR;
    d = int'(in[15:11]) % NR;
    sv = $signed(in[15:0]);
    im = W'(sv);
    av = mreg[s];
    bv = mreg[t];
    mpc = mpc + 4;
    e_cyc = 2; e_mem = 0; e_we = 0; e_halt = 0; e_addr = '0; e_wd = '0;
    wr = 0; wi = 0; r = '0;
    case (in[31:26])
      6'h00: begin
        wr = 1; wi = d; e_cyc = 4;
        case (in[5:0])
          6'h20: r = av + bv;
          6'h22: r = av - bv;
          6'h24: r = av & bv;
          6'h25: r = av | bv;
          6'h2A: r = ($signed(av) < $signed(bv)) ? W'(1) : W'(0);
          default: begin wr = 0; e_cyc = 2; end
        endcase
      end
      6'h08: begin wr = 1; wi = t; r = av + im; e_cyc = 4; end
      6'h23: begin e_mem = 1; e_addr = av + im; wr = 1; wi = t; r = mmem[e_addr[7:2]]; e_cyc = 5; end
      6'h2B: begin e_mem = 1; e_we = 1; e_addr = av + im; e_wd = bv; mmem[e_addr[7:2]] = bv; e_cyc = 4; end
      6'h04: begin e_cyc = 3; if (av == bv) mpc = mpc + im * 4; end
`ifdef MC_DATAPATH_BNE_EN
      6'h05: begin e_cyc = 3; if (av != bv) mpc = mpc + im * 4; end
`endif
      6'h02: begin e_cyc = 3; mpc = (mpc & ~W'(32'h0FFF_FFFF)) | W'(in[25:0]) * 4; end
      6'h3F: e_halt = 1;
      default: ;
    endcase
    if (wr && wi != 0) mreg[wi] = r;
  endtask
  task automatic do_reset();
    rst = 1;
    dmem_ready = 0;
    @(posedge clk); #1;
    check("rst_pc", pc, 0);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    @(posedge clk); #1;
    rst = 0;
    mpc = '0;
    mcnt = 0;
    for (int i = 0; i < NR; i++) mreg[i] = '0;
    for (int i = 0; i < 64; i++) mmem[i] = '0;
  endtask
  task automatic step_instr();
    int cyc, waits;
    bit done;
    logic [W-1:0] a0;
    mstep();
    a0 = e_addr;
    cyc = 0; waits = 0; done = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (dmem_req) begin
        dmem_ready = mcnt >= dly;
        mcnt++;
      end else begin
        dmem_ready = 0;
        mcnt = 0;
        dly = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 2));
      end
      #1;
      cyc++;
      if (dmem_req) begin
        check("mem_addr", dmem_addr, a0);
        check("mem_we", dmem_we, e_we);
        if (e_we) check("mem_wdata", dmem_wdata, e_wd);
        if (!dmem_ready) waits++;
      end
      done = retire;
    end
    check("retire_seen", done, 1);
    check("cycles", cyc, e_cyc + waits);
    last_cyc = cyc;
    @(posedge clk); #1;
    check("pc", pc, mpc);
    check("halted", halted, e_halt);
    for (int i = 0; i < NR; i++) check("reg", dut.rf[i], mreg[i]);
    if (e_we) check("dmem", dmem[a0[7:2]], mmem[a0[7:2]]);
  endtask
  function automatic int rr();
    return int'($urandom_range(0, 7));
  endfunction
  initial begin
    int lim, any_ret, n;
    logic [W-1:0] hpc;
    // directed: arithmetic chain, slow store, load, $0 write, bne, jump, halt
    clear_imem();
    imem[0] = i_i(8, 0, 1, 7);
    imem[1] = i_i(8, 0, 2, -3);
    imem[2] = r_i(6'h22, 1, 2, 3);
    imem[3] = r_i(6'h2A, 2, 1, 4);
    imem[4] = i_i(6'h2B, 0, 3, 8);
    imem[5] = i_i(6'h23, 0, 5, 8);
    imem[6] = i_i(8, 0, 0, 9);
    imem[7] = i_i(5, 1, 2, 4);
    imem[8] = j_i(32'h40);
    imem[12] = j_i(32'h40);
    do_reset();
    fixed_dly = 3;
    step_instr();
    check("first_pc", pc, 4);
    check("first_cyc", last_cyc, 4);
    for (int i = 0; i < 3; i++) step_instr();
    check("r2", dut.rf[2], W == 64 ? 64'hFFFF_FFFF_FFFF_FFFD : 64'hFFFF_FFFD);
    check("r3", dut.rf[3], 10);
    check("r4", dut.rf[4], 1);
    step_instr();
    check("sw_cyc", last_cyc, 7);
    step_instr();
    check("r5", dut.rf[5], 10);
    step_instr();
    check("r0", dut.rf[0], 0);
    step_instr();
`ifdef MC_DATAPATH_BNE_EN
    check("bne_pc", pc, 32'h30);
    check("bne_cyc", last_cyc, 3);
`else
    check("bne_pc", pc, 32'h20);
    check("bne_cyc", last_cyc, 2);
`endif
    step_instr();
    check("j_pc", pc, 32'h100);
    step_instr();
    check("halt", halted, 1);
    hpc = pc;
    any_ret = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (retire) any_ret = 1;
    end
    check("halt_sticky", halted, 1);
    check("halt_pc", pc, hpc);
    check("halt_noret", any_ret, 0);
    // directed: beq $0,$0,-1 at 0x20 keeps returning to itself
    clear_imem();
    imem[0] = j_i(8);
    imem[8] = i_i(4, 0, 0, -1);
    do_reset();
    step_instr();
    for (int i = 0; i < 4; i++) begin
      step_instr();
      check("loop_pc", pc, 32'h20);
      check("loop_cyc", last_cyc, 3);
    end
    // random forward-only programs with random memory latency
    for (int p = 0; p < 4; p++) begin
      clear_imem();
      for (int k = 0; k < 63; k++) begin
        lim = 62 - k > 3 ? 3 : 62 - k;
        case ($urandom_range(0, 9))
          0, 1: imem[k] = i_i(8, rr(), rr(), int'($urandom_range(0, 65535)));
          2, 3: imem[k] = r_i(($urandom_range(0, 4) == 0) ? 6'h2A : ($urandom_range(0, 1) ? 6'h20 : 6'h22) | 6'(int'($urandom_range(0, 1)) * 4), rr(), rr(), rr());
          4: imem[k] = r_i(int'($urandom_range(0, 63)), rr(), rr(), rr());
          5: imem[k] = i_i(6'h23, rr(), rr(), 4 * int'($urandom_range(0, 15)));
          6: imem[k] = i_i(6'h2B, rr(), rr(), 4 * int'($urandom_range(0, 15)));
          7: imem[k] = i_i(4, rr(), rr(), int'($urandom_range(0, lim)));
          8: imem[k] = j_i(k + 1 + int'($urandom_range(0, lim)));
          default: imem[k] = i_i($urandom_range(0, 1) ? 5 : 6'h10, rr(), rr(), int'($urandom_range(0, lim)));
        endcase
      end
      do_reset();
      fixed_dly = -1;
      n = 0;
      e_halt = 0;
      while (!e_halt && n < 80) begin
        step_instr();
        n++;
      end
      check("rand_halt", halted, 1);
    end
    // reset in the middle of a stalled load
    clear_imem();
    imem[0] = i_i(8, 0, 6, 77);
    imem[1] = i_i(6'h2B, 0, 6, 8);
    imem[2] = i_i(6'h23, 0, 5, 8);
    do_reset();
    fixed_dly = 0;
    step_instr();
    step_instr();
    dmem_ready = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dmem_req && n < 20);
    check("mid_req_seen", dmem_req, 1);
    rst = 1;
    @(posedge clk); #1;
    check("mid_req_drop", dmem_req, 0);
    check("mid_pc", pc, 0);
    check("mid_r5", dut.rf[5], 0);
    rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
